// File: rtl/uart_baud_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_pkg : shared config-FSM state type and increment helper
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_baud_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  // round(baud * osr * 2^acc_width / clk_freq) in 64-bit arithmetic
  function automatic logic [63:0] calc_inc(input logic [63:0] clk_freq,
                                           input logic [63:0] baud,
                                           input logic [63:0] osr,
                                           input int unsigned acc_width);
    logic [63:0] num;
    num = (baud * osr) << acc_width;
    return (num + (clk_freq >> 1)) / clk_freq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_chan : one fractional phase accumulator plus OSR tick divider
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_baud_chan #(
  parameter int unsigned           ACC_WIDTH = 24,
  parameter int unsigned           OSR       = 16,
  parameter logic [ACC_WIDTH-1:0]  INC_RST   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] inc,
  input  logic                 load,
  input  logic                 sync,
  output logic                 os_tick,
  output logic                 baud_tick,
  output logic                 active
);

  localparam int unsigned      CNT_W    = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ACC_WIDTH:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic                 en_q, en_d;
  logic [CNT_W-1:0]     os_cnt_q, os_cnt_d;

  always_comb begin
    acc_d    = acc_q;
    os_cnt_d = os_cnt_q;
    inc_d    = inc_q;
    en_d     = en_q;
    if (en_q) begin
      acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + {1'b0, inc_q};
      if (acc_q[ACC_WIDTH]) begin
        os_cnt_d = (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + CNT_ONE;
      end
      if (sync) begin
        acc_d    = '0;
        os_cnt_d = '0;
      end
    end else begin
      acc_d    = '0;
      os_cnt_d = '0;
    end
    // A write that disables the channel clears the phase on the same edge
    if (load) begin
      inc_d = inc;
      en_d  = en;
      if (!en) begin
        acc_d    = '0;
        os_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      os_cnt_q <= '0;
      inc_q    <= INC_RST;
      en_q     <= 1'b1;
    end else begin
      acc_q    <= acc_d;
      os_cnt_q <= os_cnt_d;
      inc_q    <= inc_d;
      en_q     <= en_d;
    end
  end

  assign os_tick   = acc_q[ACC_WIDTH];
  assign baud_tick = acc_q[ACC_WIDTH] && (os_cnt_q == CNT_LAST);
  assign active    = en_q;

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_gen_mc : multi-channel programmable fractional baud generator
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_baud_gen_mc
  import uart_baud_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned OSR          = 16,
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned DEFAULT_BAUD = 115_200,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_en,
  input  logic [N_CH-1:0]      sync,
  output logic [N_CH-1:0]      os_tick,
  output logic [N_CH-1:0]      baud_tick,
  output logic [N_CH-1:0]      active
);

  localparam logic [63:0] DEFAULT_INC =
    calc_inc(64'(CLK_FREQ), 64'(DEFAULT_BAUD), 64'(OSR), ACC_WIDTH);

  if (DEFAULT_INC == 64'd0 || DEFAULT_INC >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
    $error("uart_baud_gen_mc: DEFAULT_INC does not fit the accumulator");
  end

  cfg_state_t           state_q;
  logic                 cfg_ready_q;
  logic [CH_W-1:0]      pend_ch_q;
  logic [ACC_WIDTH-1:0] pend_inc_q;
  logic                 pend_en_q;

  logic                 ch_valid;
  logic                 cfg_fire;
  logic                 apply_pend;
  logic [N_CH-1:0]      load_vec;
  logic [ACC_WIDTH-1:0] new_inc;
  logic                 new_en;

  assign ch_valid  = 32'(cfg_ch) < N_CH;
  assign cfg_fire  = cfg_valid && cfg_ready_q && ch_valid;
  assign cfg_ready = cfg_ready_q;

  // Disabled targets are written at once; running targets wait for a bit boundary
  always_comb begin
    load_vec   = '0;
    new_inc    = cfg_inc;
    new_en     = cfg_en;
    apply_pend = 1'b0;
    if (state_q == PENDING) begin
      new_inc             = pend_inc_q;
      new_en              = pend_en_q;
      apply_pend          = baud_tick[pend_ch_q] || sync[pend_ch_q];
      load_vec[pend_ch_q] = apply_pend;
    end else if (cfg_fire && !active[cfg_ch]) begin
      load_vec[cfg_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
      pend_ch_q   <= '0;
      pend_inc_q  <= '0;
      pend_en_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_fire && active[cfg_ch]) begin
            state_q     <= PENDING;
            cfg_ready_q <= 1'b0;
            pend_ch_q   <= cfg_ch;
            pend_inc_q  <= cfg_inc;
            pend_en_q   <= cfg_en;
          end
        end
        PENDING: begin
          if (apply_pend) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    uart_baud_chan #(
      .ACC_WIDTH (ACC_WIDTH),
      .OSR       (OSR),
      .INC_RST   (DEFAULT_INC[ACC_WIDTH-1:0])
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (new_en),
      .inc       (new_inc),
      .load      (load_vec[i]),
      .sync      (sync[i]),
      .os_tick   (os_tick[i]),
      .baud_tick (baud_tick[i]),
      .active    (active[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_baud_gen_mc : scoreboard bench, expected tick cycles per channel
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_baud_gen_mc;

  localparam int     N_CH    = 3;
  localparam int     OSR     = 16;
  localparam longint ONE     = 64'd1 << 24;
  localparam longint DEF_INC = 309238;   // round(115200*16*2^24/100e6)

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch    = '0;
  logic [23:0] cfg_inc   = '0;
  logic        cfg_en    = 1'b0;
  logic [2:0]  sync      = '0;
  logic [2:0]  os_tick;
  logic [2:0]  baud_tick;
  logic [2:0]  active;

  uart_baud_gen_mc #(
    .N_CH         (N_CH),
    .ACC_WIDTH    (24),
    .OSR          (OSR),
    .CLK_FREQ     (100_000_000),
    .DEFAULT_BAUD (115_200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_en    (cfg_en),
    .sync      (sync),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .active    (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected cycle numbers of each tick, per channel
  int exp_os[N_CH][$];
  int exp_bd[N_CH][$];

  // Phase segment per channel: low accumulator bits equal r0 after edge org
  longint s_org[N_CH];
  longint s_r0[N_CH];
  longint s_inc[N_CH];
  int     s_cnt0[N_CH];
  int     s_n[N_CH];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint tick_at(input int c, input int n);
    return s_org[c] + (longint'(n) * ONE - s_r0[c] + s_inc[c] - 1) / s_inc[c];
  endfunction

  function automatic longint phase_at(input int c, input longint a);
    return (s_r0[c] + (a - s_org[c]) * s_inc[c]) % ONE;
  endfunction

  function automatic longint next_baud(input int c, input longint from);
    for (int n = 1; n < 4096; n++) begin
      if (((s_cnt0[c] + n) % OSR == 0) && tick_at(c, n) >= from) return tick_at(c, n);
    end
    return -1;
  endfunction

  task automatic new_seg(input int c, input longint org, input longint r0,
                         input longint inc, input int cnt0);
    s_org[c] = org; s_r0[c] = r0; s_inc[c] = inc; s_cnt0[c] = cnt0; s_n[c] = 1;
  endtask

  task automatic extend(input int c, input longint upto);
    longint t;
    if (s_inc[c] == 0) return;
    t = tick_at(c, s_n[c]);
    while (t <= upto) begin
      exp_os[c].push_back(int'(t));
      if ((s_cnt0[c] + s_n[c]) % OSR == 0) exp_bd[c].push_back(int'(t));
      s_n[c]++;
      t = tick_at(c, s_n[c]);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < N_CH; k++) extend(k, c);
    while (cyc < c) tick1();
    @(negedge clk);
    #1;
    for (int k = 0; k < N_CH; k++) begin
      chk($sformatf("os_tick[%0d] missing count", k), exp_os[k].size(), 0);
      chk($sformatf("baud_tick[%0d] missing count", k), exp_bd[k].size(), 0);
    end
  endtask

  task automatic send(input int ch, input int inc, input bit en);
    for (int k = 0; k < N_CH; k++) extend(k, cyc + 1);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_inc = 24'(inc); cfg_en = en;
    tick1();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_sync(input logic [2:0] mask);
    for (int k = 0; k < N_CH; k++) if (!mask[k]) extend(k, cyc + 1);
    sync = mask;
    tick1();
    sync = '0;
    for (int k = 0; k < N_CH; k++) if (mask[k] && s_inc[k] != 0) new_seg(k, cyc, 0, s_inc[k], 0);
  endtask

  // Monitor: every observed tick must be the next expected one, on its cycle
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (os_tick[c] === 1'b1) begin
        if (exp_os[c].size() == 0) chk($sformatf("os_tick[%0d] unexpected", c), cyc, -1);
        else chk($sformatf("os_tick[%0d] cycle", c), cyc, exp_os[c].pop_front());
      end
      if (baud_tick[c] === 1'b1) begin
        if (exp_bd[c].size() == 0) chk($sformatf("baud_tick[%0d] unexpected", c), cyc, -1);
        else chk($sformatf("baud_tick[%0d] cycle", c), cyc, exp_bd[c].pop_front());
      end
    end
  end

  initial begin
    longint a;
    int     t;

    repeat (3) tick1();
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) new_seg(k, cyc, 0, DEF_INC, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset active", active, 3'b111);
    chk("reset os_tick", os_tick, 0);
    chk("reset baud_tick", baud_tick, 0);

    // Default rate on every channel
    run_to(3000);

    // Retune running ch0: held pending until its next baud tick
    send(0, 618476, 1'b1);
    t = cyc;
    chk("cfg_ready while ch0 pending", cfg_ready, 0);
    a = next_baud(0, t) + 1;
    run_to(int'(a) - 1);
    chk("cfg_ready on applying baud cycle", cfg_ready, 0);
    new_seg(0, a, phase_at(0, a), 618476, 0);
    tick1();
    chk("cfg_ready after ch0 apply", cfg_ready, 1);
    run_to(cyc + 4000);

    // Disable ch1 at its bit boundary
    send(1, int'(DEF_INC), 1'b0);
    t = cyc;
    chk("cfg_ready while ch1 pending", cfg_ready, 0);
    a = next_baud(1, t) + 1;
    run_to(int'(a) - 1);
    chk("active[1] before disable", active[1], 1);
    new_seg(1, a, 0, 0, 0);
    tick1();
    chk("active[1] after disable", active[1], 0);
    chk("cfg_ready after ch1 apply", cfg_ready, 1);
    run_to(cyc + 100);
    pulse_sync(3'b010);
    run_to(cyc + 100);
    chk("active[1] unaffected by sync", active[1], 0);

    // Re-enable ch1 immediately with a new increment
    send(1, 1000000, 1'b1);
    chk("cfg_ready after immediate write", cfg_ready, 1);
    chk("active[1] after re-enable", active[1], 1);
    new_seg(1, cyc, 0, 1000000, 0);
    run_to(cyc + 2000);

    // Mid-bit phase restart on ch0
    run_to(cyc + 300);
    pulse_sync(3'b001);
    run_to(cyc + 3000);

    // Out-of-range channel is discarded
    send(3, 5, 1'b0);
    chk("cfg_ready after discard", cfg_ready, 1);
    chk("active after discard", active, 3'b111);
    run_to(cyc + 1500);

    // Reset while a request is pending
    send(2, 618476, 1'b1);
    chk("cfg_ready while ch2 pending", cfg_ready, 0);
    rst = 1'b1;
    tick1();
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) new_seg(k, cyc, 0, DEF_INC, 0);
    chk("cfg_ready after mid-pending reset", cfg_ready, 1);
    chk("active after mid-pending reset", active, 3'b111);
    chk("os_tick after mid-pending reset", os_tick, 0);
    chk("baud_tick after mid-pending reset", baud_tick, 0);
    run_to(cyc + 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
